touch_array: RTL
================

TOUCH_ARRAY -- requirements
Module: touch_array

Interface
REQ-001 Parameter N_CH, default 2, number of touch sensor channels (1..16).
REQ-002 Parameter DEB_CYC, default 16, consecutive stable cycles required to accept a channel change (2..65535).
REQ-003 Parameter MIN_ACTIVE, default 2, active-channel threshold used in THRESH mode (1..N_CH).
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 touch  input  N_CH  raw, asynchronous sensor levels; bit i is channel i; 1 = touched.
REQ-007 mode  input  2  combine mode: 00 ALL, 01 ANY, 10 THRESH, 11 reserved (behaves as ALL).
REQ-008 touched_ch  output  N_CH  debounced per-channel levels.
REQ-009 active_cnt  output  $clog2(N_CH+1)  registered count of set bits in touched_ch.
REQ-010 touched  output  1  registered combined touch level.
REQ-011 touch_pulse  output  1  one-cycle strobe on each 0->1 transition of touched.

Function
REQ-012 Each touch bit SHALL pass through a 2-flop synchroniser before any other use.
REQ-013 Each channel SHALL have a debounce counter, width $clog2(DEB_CYC+1), that clears whenever the synchronised input equals touched_ch[i].
REQ-014 The counter SHALL increment while the synchronised input differs from touched_ch[i]; at count DEB_CYC-1 with the input still differing, touched_ch[i] SHALL toggle and the counter SHALL clear in that same cycle.
REQ-015 Any glitch shorter than DEB_CYC synchronised cycles SHALL leave touched_ch[i] unchanged; the counter SHALL restart from 0 after each glitch.
REQ-016 A raw input change held stable SHALL appear on touched_ch[i] exactly 2+DEB_CYC cycles later.
REQ-017 active_cnt SHALL be registered from the current touched_ch, one cycle after touched_ch changes.
REQ-018 The combine condition SHALL be: ALL = every touched_ch bit set; ANY = at least one bit set; THRESH = popcount(touched_ch) >= MIN_ACTIVE.
REQ-019 Combine FSM states: IDLE (touched=0) and ACTIVE (touched=1); IDLE->ACTIVE when the condition is true; ACTIVE->IDLE when it is false; otherwise hold.
REQ-020 touched SHALL follow the condition with 1-cycle latency, i.e. 3+DEB_CYC cycles from a stable raw edge.
REQ-021 touch_pulse SHALL be 1 only in the first cycle touched is 1 after being 0; it is never asserted on 1->0 and never for two consecutive cycles.
REQ-022 A mode change SHALL take effect on the next clock edge; if it causes touched to go 0->1, touch_pulse SHALL fire exactly as for an input-driven rise.
REQ-023 Simultaneous toggles on several channels SHALL be debounced independently; touched SHALL re-evaluate once on the cycle after they land.
REQ-024 When N_CH=1, ALL, ANY and THRESH (MIN_ACTIVE=1) SHALL behave identically.

Reset
REQ-025 While rst=1: synchronisers, debounce counters, touched_ch, active_cnt, touched and touch_pulse SHALL all be 0, and the FSM SHALL be in IDLE.
REQ-026 rst asserted mid-debounce or in ACTIVE SHALL discard all progress; no touch_pulse SHALL be emitted on or after reset release unless the condition becomes newly true through full debounce.
REQ-027 After reset release with touch held at all-ones, touched SHALL rise 3+DEB_CYC cycles after the first cycle with rst=0.

Verification (N_CH=2, DEB_CYC=4, MIN_ACTIVE=2 unless stated)
REQ-028 ALL mode; touch 00->11 held -> touched_ch=11 at cycle +6, touched=1 and touch_pulse=1 for one cycle at +7, active_cnt=2 at +7.
REQ-029 ALL mode; touch=11 steady, then channel 0 glitches low for 3 cycles -> touched_ch, touched and touch_pulse unchanged; the glitch held 4 cycles -> touched_ch=10 and touched=0 one cycle later, with no pulse.
REQ-030 touch=01 steady, mode switched 00->01 -> touched=1 with touch_pulse=1 on the next edge; switching back to 00 -> touched=0 on the next edge.
REQ-031 N_CH=4, MIN_ACTIVE=3, THRESH; touched_ch steps 0011->0111->0110 -> touched goes 0->1 (one pulse) then 1->0, with active_cnt showing 2, 3, 2.
REQ-032 ALL mode, touched=1; assert rst for 1 cycle with touch held at 11 -> all outputs 0 during reset; touched re-rises exactly 7 cycles after release with a single touch_pulse.
REQ-033 mode=11 with touch=01 then 11 -> behaves as ALL: touched=0 for 01, then 1 with one pulse for 11.

Source files
------------

// File: rtl/touch_array.sv
// Multi-channel touch front end: 2-flop sync, per-channel debounce, ALL/ANY/THRESH combine with rise strobe.
// Latency: touched_ch 2+DEB_CYC cycles after a stable raw edge, touched/active_cnt/touch_pulse one more; no backpressure.
module touch_array #(
   parameter int N_CH       = 2,
   parameter int DEB_CYC    = 16,
   parameter int MIN_ACTIVE = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_CH-1:0]           touch,
   input  logic [1:0]                mode,
   output logic [N_CH-1:0]           touched_ch,
   output logic [$clog2(N_CH+1)-1:0] active_cnt,
   output logic                      touched,
   output logic                      touch_pulse
);
   localparam int CW = $clog2(N_CH+1);
   localparam int DW = $clog2(DEB_CYC+1);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC-1);
   localparam logic [CW-1:0] MIN_CNT  = CW'(MIN_ACTIVE);

   typedef enum logic {IDLE, ACTIVE} state_t;

   logic [N_CH-1:0] sync1;
   logic [N_CH-1:0] sync2;
   logic [DW-1:0]   deb_cnt [N_CH];
   logic [CW-1:0]   pop;
   logic            cond;
   logic            rise;
   state_t          state;
   state_t          state_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= touch;
         sync2 <= sync1;
      end
   end

   // A channel flips only after DEB_CYC consecutive disagreeing samples; any agreement restarts the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         touched_ch <= '0;
         for (int i = 0; i < N_CH; i++) begin
            deb_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (sync2[i] == touched_ch[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_LAST) begin
               deb_cnt[i]    <= '0;
               touched_ch[i] <= ~touched_ch[i];
            end else begin
               deb_cnt[i] <= deb_cnt[i] + DW'(1);
            end
         end
      end
   end

   always_comb begin
      pop = '0;
      for (int i = 0; i < N_CH; i++) begin
         pop = pop + CW'(touched_ch[i]);
      end
      cond = &touched_ch;
      case (mode)
         2'b01:   cond = (pop != '0);
         2'b10:   cond = (pop >= MIN_CNT);
         default: cond = &touched_ch;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      rise      = 1'b0;
      case (state)
         IDLE: begin
            if (cond) begin
               state_nxt = ACTIVE;
               rise      = 1'b1;
            end
         end
         ACTIVE: begin
            if (!cond) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         active_cnt  <= '0;
         touch_pulse <= 1'b0;
      end else begin
         active_cnt  <= pop;
         touch_pulse <= rise;
      end
   end

   assign touched = (state == ACTIVE);

endmodule
